// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul sequencer and its accumulate unit.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BUS_WIDTH  = 16;
    localparam int DIM_W          = 2;

    // Column-major element slot, matching the multiplier's C layout.
    function automatic int elem_idx(input int r, input int c, input int max_dim);
        return c * max_dim + r;
    endfunction

endpackage

// File: rtl/matmul_acc_unit.sv
// Per-element mask, optional signed wrap-around accumulate and overflow flag merge.
module matmul_acc_unit
    import matmul_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int MAX_DIM   = 2,
    localparam int NEL      = MAX_DIM * MAX_DIM,
    localparam int RES_W    = NEL * BUS_WIDTH
) (
    input  logic [DIM_W-1:0] n_dim_i,
    input  logic [DIM_W-1:0] m_dim_i,
    input  logic             acc_i,
    input  logic [RES_W-1:0] buf_i,
    input  logic [RES_W-1:0] prod_i,
    input  logic [NEL-1:0]   prod_flags_i,
    output logic [RES_W-1:0] sum_o,
    output logic [NEL-1:0]   flags_o
);

    logic [BUS_WIDTH-1:0] a_el;
    logic [BUS_WIDTH-1:0] b_el;
    logic [BUS_WIDTH-1:0] s_el;
    logic                 ovf;

    always_comb begin
        sum_o   = '0;
        flags_o = '0;
        a_el    = '0;
        b_el    = '0;
        s_el    = '0;
        ovf     = 1'b0;
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                // Elements outside the active (n+1)x(m+1) window stay zero.
                if (r <= int'(n_dim_i) && c <= int'(m_dim_i)) begin
                    a_el = buf_i[elem_idx(r, c, MAX_DIM)*BUS_WIDTH +: BUS_WIDTH];
                    b_el = prod_i[elem_idx(r, c, MAX_DIM)*BUS_WIDTH +: BUS_WIDTH];
                    s_el = a_el + b_el;
                    ovf  = (a_el[BUS_WIDTH-1] == b_el[BUS_WIDTH-1]) &&
                           (s_el[BUS_WIDTH-1] != a_el[BUS_WIDTH-1]);
                    if (acc_i) begin
                        sum_o[elem_idx(r, c, MAX_DIM)*BUS_WIDTH +: BUS_WIDTH] = s_el;
                        flags_o[elem_idx(r, c, MAX_DIM)] = prod_flags_i[elem_idx(r, c, MAX_DIM)] | ovf;
                    end else begin
                        sum_o[elem_idx(r, c, MAX_DIM)*BUS_WIDTH +: BUS_WIDTH] = b_el;
                        flags_o[elem_idx(r, c, MAX_DIM)] = prod_flags_i[elem_idx(r, c, MAX_DIM)];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Command-driven sequencer for one systolic matrix multiplier, with result accumulation.
//   state   | meaning
//   IDLE    | ready for a command; bad dims give a one-cycle err_o pulse
//   RUN     | mul_start_o held, watchdog counting, waiting for mul_finish_i
//   CAPTURE | finish_write to multiplier, result buffer updated
//   DONE    | result presented until res_ready_i
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int TIMEOUT    = 16,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int NEL       = MAX_DIM * MAX_DIM,
    localparam int OP_W      = NEL * DATA_WIDTH,
    localparam int RES_W     = NEL * BUS_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_n_dim_i,
    input  logic [1:0]       cmd_k_dim_i,
    input  logic [1:0]       cmd_m_dim_i,
    input  logic             cmd_acc_i,
    input  logic [OP_W-1:0]  cmd_a_matrix_i,
    input  logic [OP_W-1:0]  cmd_b_matrix_i,
    output logic             mul_start_o,
    output logic             mul_finish_write_o,
    output logic [1:0]       mul_n_dim_o,
    output logic [1:0]       mul_k_dim_o,
    output logic [1:0]       mul_m_dim_o,
    output logic [OP_W-1:0]  mul_a_matrix_o,
    output logic [OP_W-1:0]  mul_b_matrix_o,
    input  logic             mul_finish_i,
    input  logic [RES_W-1:0] mul_c_matrix_i,
    input  logic [NEL-1:0]   mul_flags_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [RES_W-1:0] res_c_matrix_o,
    output logic [NEL-1:0]   res_flags_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e           state_q;
    logic             cmd_ready_q;
    logic             mul_start_q;
    logic             mul_fw_q;
    logic             res_valid_q;
    logic             busy_q;
    logic             err_q;
    logic             acc_q;
    logic [1:0]       n_dim_q;
    logic [1:0]       k_dim_q;
    logic [1:0]       m_dim_q;
    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  b_q;
    logic [RES_W-1:0] buf_q;
    logic [NEL-1:0]   flags_q;
    logic [WD_W-1:0]  wdog_q;
    logic [RES_W-1:0] buf_d;
    logic [NEL-1:0]   flags_d;
    logic             dims_ok;

    assign dims_ok = (int'(cmd_n_dim_i) < MAX_DIM) &&
                     (int'(cmd_k_dim_i) < MAX_DIM) &&
                     (int'(cmd_m_dim_i) < MAX_DIM);

    matmul_acc_unit #(
        .BUS_WIDTH (BUS_WIDTH),
        .MAX_DIM   (MAX_DIM)
    ) u_acc (
        .n_dim_i      (n_dim_q),
        .m_dim_i      (m_dim_q),
        .acc_i        (acc_q),
        .buf_i        (buf_q),
        .prod_i       (mul_c_matrix_i),
        .prod_flags_i (mul_flags_i),
        .sum_o        (buf_d),
        .flags_o      (flags_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            mul_start_q <= 1'b0;
            mul_fw_q    <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            acc_q       <= 1'b0;
            n_dim_q     <= '0;
            k_dim_q     <= '0;
            m_dim_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            buf_q       <= '0;
            flags_q     <= '0;
            wdog_q      <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        if (!dims_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            n_dim_q     <= cmd_n_dim_i;
                            k_dim_q     <= cmd_k_dim_i;
                            m_dim_q     <= cmd_m_dim_i;
                            a_q         <= cmd_a_matrix_i;
                            b_q         <= cmd_b_matrix_i;
                            acc_q       <= cmd_acc_i;
                            wdog_q      <= '0;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            mul_start_q <= 1'b1;
                            state_q     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (mul_finish_i) begin
                        mul_fw_q <= 1'b1;
                        state_q  <= ST_CAPTURE;
                    end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                        err_q       <= 1'b1;
                        mul_start_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    buf_q       <= buf_d;
                    flags_q     <= flags_d;
                    mul_start_q <= 1'b0;
                    mul_fw_q    <= 1'b0;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o        = cmd_ready_q;
    assign mul_start_o        = mul_start_q;
    assign mul_finish_write_o = mul_fw_q;
    assign mul_n_dim_o        = n_dim_q;
    assign mul_k_dim_o        = k_dim_q;
    assign mul_m_dim_o        = m_dim_q;
    assign mul_a_matrix_o     = a_q;
    assign mul_b_matrix_o     = b_q;
    assign res_valid_o        = res_valid_q;
    assign res_c_matrix_o     = buf_q;
    assign res_flags_o        = flags_q;
    assign busy_o             = busy_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: acts as the multiplier and the host, scoreboards results.
module tb_matmul_sequencer;

    localparam int DW   = 8;
    localparam int BW   = 16;
    localparam int MD   = 2;
    localparam int TO   = 16;
    localparam int NEL  = MD * MD;
    localparam int OPW  = NEL * DW;
    localparam int RESW = NEL * BW;

    logic            clk;
    logic            rst_ni;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [1:0]      cmd_n_dim_i, cmd_k_dim_i, cmd_m_dim_i;
    logic            cmd_acc_i;
    logic [OPW-1:0]  cmd_a_matrix_i, cmd_b_matrix_i;
    logic            mul_start_o, mul_finish_write_o;
    logic [1:0]      mul_n_dim_o, mul_k_dim_o, mul_m_dim_o;
    logic [OPW-1:0]  mul_a_matrix_o, mul_b_matrix_o;
    logic            mul_finish_i;
    logic [RESW-1:0] mul_c_matrix_i;
    logic [NEL-1:0]  mul_flags_i;
    logic            res_valid_o, res_ready_i;
    logic [RESW-1:0] res_c_matrix_o;
    logic [NEL-1:0]  res_flags_o;
    logic            busy_o, err_o;

    matmul_sequencer #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .TIMEOUT(TO)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .cmd_valid_i        (cmd_valid_i),
        .cmd_ready_o        (cmd_ready_o),
        .cmd_n_dim_i        (cmd_n_dim_i),
        .cmd_k_dim_i        (cmd_k_dim_i),
        .cmd_m_dim_i        (cmd_m_dim_i),
        .cmd_acc_i          (cmd_acc_i),
        .cmd_a_matrix_i     (cmd_a_matrix_i),
        .cmd_b_matrix_i     (cmd_b_matrix_i),
        .mul_start_o        (mul_start_o),
        .mul_finish_write_o (mul_finish_write_o),
        .mul_n_dim_o        (mul_n_dim_o),
        .mul_k_dim_o        (mul_k_dim_o),
        .mul_m_dim_o        (mul_m_dim_o),
        .mul_a_matrix_o     (mul_a_matrix_o),
        .mul_b_matrix_o     (mul_b_matrix_o),
        .mul_finish_i       (mul_finish_i),
        .mul_c_matrix_i     (mul_c_matrix_i),
        .mul_flags_i        (mul_flags_i),
        .res_valid_o        (res_valid_o),
        .res_ready_i        (res_ready_i),
        .res_c_matrix_o     (res_c_matrix_o),
        .res_flags_o        (res_flags_o),
        .busy_o             (busy_o),
        .err_o              (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      n, k, m;
        logic            acc;
        logic [OPW-1:0]  a, b;
        logic [RESW-1:0] exp_c;
        logic [NEL-1:0]  exp_f;
    } vec_t;

    typedef struct {
        logic [RESW-1:0] c;
        logic [NEL-1:0]  f;
    } res_t;

    res_t sb_q[$];
    res_t sb_e;
    vec_t vecs[6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // A/B: element (r,c) at word r*MD+c.
    function automatic logic [OPW-1:0] pack_op(input int e00, input int e01, input int e10, input int e11);
        logic [OPW-1:0] v;
        v = '0;
        v[0*DW +: DW] = DW'(e00);
        v[1*DW +: DW] = DW'(e01);
        v[2*DW +: DW] = DW'(e10);
        v[3*DW +: DW] = DW'(e11);
        return v;
    endfunction

    // C: element (r,c) at slot c*MD+r.
    function automatic logic [RESW-1:0] pack_res(input int c00, input int c01, input int c10, input int c11);
        logic [RESW-1:0] v;
        v = '0;
        v[0*BW +: BW] = BW'(c00);
        v[1*BW +: BW] = BW'(c10);
        v[2*BW +: BW] = BW'(c01);
        v[3*BW +: BW] = BW'(c11);
        return v;
    endfunction

    // Multiplier model; out-of-window elements carry junk and a set flag.
    function automatic logic [RESW-1:0] mul_model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                                  input logic [1:0] n, input logic [1:0] k, input logic [1:0] m);
        logic [RESW-1:0] res;
        int acc;
        res = '0;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                if (r <= int'(n) && c <= int'(m)) begin
                    acc = 0;
                    for (int kk = 0; kk <= int'(k); kk++)
                        acc += $signed(a[(r*MD+kk)*DW +: DW]) * $signed(b[(kk*MD+c)*DW +: DW]);
                    res[(c*MD+r)*BW +: BW] = acc[BW-1:0];
                end else begin
                    res[(c*MD+r)*BW +: BW] = 16'hA5A5;
                end
            end
        return res;
    endfunction

    function automatic logic [NEL-1:0] junk_flags(input logic [1:0] n, input logic [1:0] m);
        logic [NEL-1:0] f;
        f = '0;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                if (r > int'(n) || c > int'(m)) f[c*MD+r] = 1'b1;
        return f;
    endfunction

    // Scoreboard consumer: compare at each result handshake.
    always @(negedge clk) begin
        #1;
        if (res_valid_o && res_ready_i) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got result %0h expected none", res_c_matrix_o);
            end else begin
                sb_e = sb_q.pop_front();
                chk("res_c", res_c_matrix_o, sb_e.c);
                chk("res_flags", res_flags_o, sb_e.f);
            end
        end
    end

    task automatic drive_cmd(input vec_t v);
        cmd_n_dim_i    = v.n;
        cmd_k_dim_i    = v.k;
        cmd_m_dim_i    = v.m;
        cmd_acc_i      = v.acc;
        cmd_a_matrix_i = v.a;
        cmd_b_matrix_i = v.b;
    endtask

    task automatic send_cmd(input vec_t v, input int lat, input bit hold);
        res_t e;
        int w;
        w = 0;
        while (!cmd_ready_o && w < 50) begin @(negedge clk); w++; end
        chk("cmd_ready_wait", cmd_ready_o, 1);
        drive_cmd(v);
        cmd_valid_i = 1'b1;
        e.c = v.exp_c;
        e.f = v.exp_f;
        sb_q.push_back(e);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk("start_t1", mul_start_o, 1);
        chk("busy_run", busy_o, 1);
        chk("ready_run", cmd_ready_o, 0);
        chk("mul_dims", {mul_n_dim_o, mul_k_dim_o, mul_m_dim_o}, {v.n, v.k, v.m});
        chk("mul_ops", {mul_a_matrix_o, mul_b_matrix_o}, {v.a, v.b});
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("start_run", mul_start_o, 1);
            chk("fw_run", mul_finish_write_o, 0);
        end
        mul_finish_i   = 1'b1;
        mul_c_matrix_i = mul_model(v.a, v.b, v.n, v.k, v.m);
        mul_flags_i    = junk_flags(v.n, v.m);
        @(negedge clk);
        mul_finish_i = 1'b0;
        chk("fw_capture", mul_finish_write_o, 1);
        chk("start_capture", mul_start_o, 1);
        chk("valid_capture", res_valid_o, 0);
        @(negedge clk);
        mul_c_matrix_i = '0;
        mul_flags_i    = '0;
        chk("fw_done", mul_finish_write_o, 0);
        chk("start_done", mul_start_o, 0);
        chk("valid_done", res_valid_o, 1);
        w = 0;
        while (!res_valid_o && w < 20) begin @(negedge clk); w++; end
        if (hold) begin
            drive_cmd(vecs[0]);
            cmd_valid_i = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("hold_valid", res_valid_o, 1);
                chk("hold_c", res_c_matrix_o, v.exp_c);
                chk("hold_ready", cmd_ready_o, 0);
                chk("hold_start", mul_start_o, 0);
            end
            cmd_valid_i = 1'b0;
        end
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        chk("valid_after", res_valid_o, 0);
        chk("ready_after", cmd_ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int cnt;
        bit got_err;

        vecs[0] = '{2'd1, 2'd1, 2'd1, 1'b0, pack_op(1, 2, 3, 4), pack_op(5, 6, 7, 8),
                    pack_res(19, 22, 43, 50), 4'b0000};
        vecs[1] = '{2'd1, 2'd1, 2'd1, 1'b1, pack_op(1, 2, 3, 4), pack_op(5, 6, 7, 8),
                    pack_res(38, 44, 86, 100), 4'b0000};
        vecs[2] = '{2'd0, 2'd1, 2'd0, 1'b0, pack_op(127, 127, 0, 0), pack_op(127, 0, 127, 0),
                    pack_res(32258, 0, 0, 0), 4'b0000};
        vecs[3] = '{2'd0, 2'd1, 2'd0, 1'b1, pack_op(127, 127, 0, 0), pack_op(127, 0, 127, 0),
                    pack_res(-1020, 0, 0, 0), 4'b0001};
        vecs[4] = '{2'd1, 2'd1, 2'd1, 1'b0, pack_op(-1, 2, 3, -4), pack_op(1, 1, 1, 1),
                    pack_res(1, 1, -1, -1), 4'b0000};
        vecs[5] = '{2'd0, 2'd0, 2'd1, 1'b1, pack_op(3, 0, 0, 0), pack_op(4, 5, 0, 0),
                    pack_res(13, 16, 0, 0), 4'b0000};

        rst_ni         = 1'b0;
        cmd_valid_i    = 1'b0;
        res_ready_i    = 1'b0;
        mul_finish_i   = 1'b0;
        mul_c_matrix_i = '0;
        mul_flags_i    = '0;
        drive_cmd(vecs[0]);
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_outs", {mul_start_o, mul_finish_write_o, res_valid_o, busy_o, err_o}, 0);
        chk("rst_buf", {res_c_matrix_o, res_flags_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) send_cmd(vecs[i], i, (i == 1));

        // Out-of-range dims: one-cycle error, nothing started.
        for (int i = 0; i < 2; i++) begin
            v = vecs[0];
            if (i == 0) v.n = 2'd2; else v.m = 2'd3;
            drive_cmd(v);
            cmd_valid_i = 1'b1;
            @(negedge clk);
            cmd_valid_i = 1'b0;
            chk("baddim_err", err_o, 1);
            chk("baddim_ready", cmd_ready_o, 1);
            chk("baddim_start", mul_start_o, 0);
            @(negedge clk);
            chk("baddim_err_clr", err_o, 0);
            chk("baddim_start2", mul_start_o, 0);
        end

        // Watchdog abort: finish never arrives.
        drive_cmd(vecs[0]);
        cmd_valid_i = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cnt = 0;
        got_err = 1'b0;
        for (int i = 0; i < TO + 5 && !got_err; i++) begin
            if (err_o) got_err = 1'b1;
            else begin
                if (mul_start_o) cnt++;
                @(negedge clk);
            end
        end
        chk("to_err_seen", got_err, 1);
        chk("to_start_cycles", cnt, TO);
        chk("to_start_low", mul_start_o, 0);
        chk("to_ready", cmd_ready_o, 1);
        chk("to_valid", res_valid_o, 0);
        chk("to_buf_kept", res_c_matrix_o, vecs[5].exp_c);
        @(negedge clk);
        chk("to_err_clr", err_o, 0);

        // Reset in the middle of RUN clears everything, including the buffer.
        drive_cmd(vecs[0]);
        cmd_valid_i = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("midrst_ready", cmd_ready_o, 1);
        chk("midrst_outs", {mul_start_o, mul_finish_write_o, res_valid_o, busy_o, err_o}, 0);
        chk("midrst_buf", {res_c_matrix_o, res_flags_o}, 0);
        chk("midrst_latch", {mul_a_matrix_o, mul_n_dim_o, mul_k_dim_o, mul_m_dim_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        v = vecs[0];
        v.acc = 1'b1;
        send_cmd(v, 2, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Controller that sequences one matrix_multiple_module instance (systolic PE array) for a command-driven host.
- Accepts a command carrying dims, operands A/B and an accumulate flag.
- Drives the multiplier's start/finish_write handshake and captures its result and overflow flags.
- Optionally accumulates into the previous result, then presents the result on a valid/ready port.
- Sits between the host register/bus front-end and the multiplier datapath.

Parameters:
DATA_WIDTH, 8, operand element width (must match multiplier).
BUS_WIDTH, 16, result element width (must match multiplier).
TIMEOUT, 16, maximum cycles in RUN waiting for mul_finish_i before abort.
MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, array side length.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready (high only in IDLE)
cmd_n_dim_i/cmd_k_dim_i/cmd_m_dim_i  in  2 each  dims minus one; A is (n+1)x(k+1), B is (k+1)x(m+1)
cmd_acc_i  in  1  add new product to held result
cmd_a_matrix_i/cmd_b_matrix_i  in  MAX_DIM*MAX_DIM*DATA_WIDTH each  flattened operands, row r at word r
mul_start_o  out  1  to multiplier start_i
mul_finish_write_o  out  1  to multiplier finish_write_i
mul_n_dim_o/mul_k_dim_o/mul_m_dim_o  out  2 each  latched dims
mul_a_matrix_o/mul_b_matrix_o  out  MAX_DIM*MAX_DIM*DATA_WIDTH each  latched operands
mul_finish_i  in  1  multiplier finish_mul_o
mul_c_matrix_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  multiplier result
mul_flags_i  in  MAX_DIM*MAX_DIM  multiplier overflow flags
res_valid_o  out  1  result valid
res_ready_i  in  1  result accepted
res_c_matrix_o  out  MAX_DIM*MAX_DIM*BUS_WIDTH  result buffer
res_flags_o  out  MAX_DIM*MAX_DIM  per-element overflow
busy_o  out  1  state != IDLE
err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (rst_ni low at posedge): state=IDLE. All outputs 0 except cmd_ready_o=1. Result buffer, flags and latched operands/dims are cleared. Applies from any state, including mid-RUN (mul_start_o drops the next cycle).
- Element (row r, col c) occupies slice index c*MAX_DIM+r in C and in the flags, matching the multiplier layout.
- IDLE: on cmd_valid_i&cmd_ready_o:
  - If any dim > MAX_DIM-1: err_o=1 for one cycle; stay IDLE; nothing latched.
  - Else latch dims, operands and acc flag; go to RUN the next cycle.
- RUN: mul_start_o=1 held continuously; the multiplier restarts its counter if start drops. A watchdog counts from 0.
  - On mul_finish_i=1: go to CAPTURE.
  - If the watchdog reaches TIMEOUT first: err_o pulse; mul_start_o=0; go to IDLE; buffer unchanged.
- CAPTURE (1 cycle): mul_start_o=1, mul_finish_write_o=1. Buffer is written:
  - Elements with r>n or c>m are forced to 0, with flag 0.
  - acc=0: buf = mul_c_matrix_i; flag = mul_flags_i bit.
  - acc=1: buf = buf + mul_c_matrix_i, BUS_WIDTH signed, wrapping; flag = mul flag OR signed-add overflow.
  - Next state: DONE.
- DONE: mul_start_o=0, mul_finish_write_o=0, res_valid_o=1. res_c_matrix_o and res_flags_o stay stable until res_ready_i=1, then go to IDLE.
- Latency: command accepted at cycle T → mul_start_o high at T+1; CAPTURE is the cycle after mul_finish_i is sampled high; res_valid_o rises one cycle after CAPTURE.
- cmd_valid_i is ignored outside IDLE. Result buffer persists across commands for accumulation; it is cleared only by reset.

Decomposition:
- Package matmul_pkg:
  - state encoding IDLE/RUN/CAPTURE/DONE
  - MAX_DIM, operand and result width constants
  - element index function c*MAX_DIM+r
- Sub-module matmul_acc_unit: combinational per-element mask, add, wrap and overflow-flag generation, instantiated once (vectorised across elements).

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], n=k=m=1, acc=0 → res_c=[[19,22],[43,50]]; flags=0; mul_start_o high from T+1 until CAPTURE; mul_finish_write_o exactly one cycle.
- Repeat the same command with acc=1 → res_c=[[38,44],[86,100]].
- n=0,k=1,m=0, A row0=[127,127], B col0=[127,127], acc=0 → C00=32258, others 0. Repeat with acc=1 → C00=-1020, flag bit0=1.
- cmd_n_dim_i=2 (MAX_DIM=2) → err_o one-cycle pulse; cmd_ready_o stays 1; mul_start_o stays 0.
- Hold mul_finish_i=0 after start → err_o at RUN cycle TIMEOUT; mul_start_o=0; back to IDLE; res_valid_o=0.
- rst_ni=0 mid-RUN → next cycle all outputs 0, cmd_ready_o=1; a following acc=1 command yields the plain product (buffer cleared). res_ready_i held low in DONE for 5 cycles → outputs stable, no new command accepted.
